// File: rtl/muldiv_wb_ctrl.sv
// muldiv_wb_ctrl: mul/div sequencing, HI/LO write enables, decode stall and write-back mux select.
// Optional HILO_FWD_EN lets MFHI/MFLO bypass the final busy cycle via wb_sel 101/110.
module muldiv_wb_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [2:0] id_md_op,
    input  logic [2:0] id_wb_src,
    input  logic       flush,
    output logic       stall,
    output logic       busy,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       md_cancel,
    output logic       hi_we,
    output logic       lo_we,
    output logic       hilo_wsel,
    output logic [2:0] wb_sel
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         md_op_q, md_op_d;
    logic               start_q, start_d, cancel_q, cancel_d;
    logic               hi_we_q, hi_we_d, lo_we_q, lo_we_d, wsel_q, wsel_d;
    logic [2:0]         wb_sel_q, wb_sel_d;
    logic               is_md, is_div, is_mt, hilo_op, reads_hilo, fwd, accept, done, in_busy;

    always_comb begin
        in_busy    = state_q == BUSY;
        is_md      = id_md_op >= 3'd1 && id_md_op <= 3'd4;
        is_div     = id_md_op == 3'd3 || id_md_op == 3'd4;
        is_mt      = id_md_op == 3'd5 || id_md_op == 3'd6;
        hilo_op    = id_md_op >= 3'd1 && id_md_op <= 3'd6;
        reads_hilo = id_wb_src == 3'd2 || id_wb_src == 3'd3;
`ifdef HILO_FWD_EN
        // Last busy cycle: the unit result is ready, so a plain MFHI/MFLO can take it directly.
        fwd        = in_busy && cnt_q == '0 && !hilo_op && reads_hilo;
`else
        fwd        = 1'b0;
`endif
        stall      = id_valid && in_busy && (hilo_op || reads_hilo) && !fwd;
        accept     = id_valid && !stall && !flush;
        done       = in_busy && cnt_q == '0 && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            md_op_q  <= 2'b00;
            start_q  <= 1'b0;
            cancel_q <= 1'b0;
            hi_we_q  <= 1'b0;
            lo_we_q  <= 1'b0;
            wsel_q   <= 1'b0;
            wb_sel_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            md_op_q  <= md_op_d;
            start_q  <= start_d;
            cancel_q <= cancel_d;
            hi_we_q  <= hi_we_d;
            lo_we_q  <= lo_we_d;
            wsel_q   <= wsel_d;
            wb_sel_q <= wb_sel_d;
        end
    end

    always_comb begin
        state_d = in_busy ? ((flush || cnt_q == '0) ? IDLE : BUSY)
                          : ((accept && is_md) ? BUSY : IDLE);
    end

    always_comb begin
        start_d  = !in_busy && accept && is_md;
        cancel_d = in_busy && flush;
        cnt_d    = start_d ? (is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1))
                 : (in_busy && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        md_op_d  = start_d ? 2'(id_md_op - 3'd1) : md_op_q;
        hi_we_d  = done || (accept && id_md_op == 3'd5);
        lo_we_d  = done || (accept && id_md_op == 3'd6);
        wsel_d   = accept && is_mt;
        wb_sel_d = !accept ? wb_sel_q
                 : fwd ? (id_wb_src[0] ? 3'b110 : 3'b101)
                 : (id_wb_src > 3'd4 ? 3'b000 : id_wb_src);
        busy      = in_busy;
        md_start  = start_q;
        md_op     = md_op_q;
        md_cancel = cancel_q;
        hi_we     = hi_we_q;
        lo_we     = lo_we_q;
        hilo_wsel = wsel_q;
        wb_sel    = wb_sel_q;
    end
endmodule

// File: tb/tb_muldiv_wb_ctrl.sv
// tb_muldiv_wb_ctrl: directed vectors with a cycle-count model of the controller plus literal checks.
module tb_muldiv_wb_ctrl;
    localparam int MUL = 4;
    localparam int DIV = 33;

    logic       clk = 1'b0, rst = 1'b1, id_valid = 1'b0, flush = 1'b0;
    logic [2:0] id_md_op = 3'd0, id_wb_src = 3'd0;
    logic       stall, busy, md_start, md_cancel, hi_we, lo_we, hilo_wsel;
    logic [1:0] md_op;
    logic [2:0] wb_sel;

    muldiv_wb_ctrl #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_md_op(id_md_op), .id_wb_src(id_wb_src),
        .flush(flush), .stall(stall), .busy(busy), .md_start(md_start), .md_op(md_op),
        .md_cancel(md_cancel), .hi_we(hi_we), .lo_we(lo_we), .hilo_wsel(hilo_wsel), .wb_sel(wb_sel)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: remaining busy cycles plus expected registered outputs.
    int         left = 0;
    bit         chk = 0;
    logic       e_start = 0, e_cancel = 0, e_hi = 0, e_lo = 0, e_wsel = 0;
    logic [1:0] e_op = 0;
    logic [2:0] e_wb = 0;

    function automatic logic e_stall();
        logic hop, rd, fw;
        hop = id_md_op >= 3'd1 && id_md_op <= 3'd6;
        rd  = id_wb_src == 3'd2 || id_wb_src == 3'd3;
`ifdef HILO_FWD_EN
        fw  = left == 1 && !hop && rd;
`else
        fw  = 1'b0;
`endif
        return id_valid && left > 0 && (hop || rd) && !fw;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            left = 0; e_start = 0; e_cancel = 0; e_hi = 0; e_lo = 0; e_wsel = 0; e_op = 0; e_wb = 0;
            chk = 1;
        end else begin
            logic s, acc, was_busy, fin;
            s        = e_stall();
            acc      = id_valid && !s && !flush;
            was_busy = left > 0;
            fin      = was_busy && left == 1 && !flush;
            e_start  = acc && id_md_op >= 3'd1 && id_md_op <= 3'd4;
            e_cancel = was_busy && flush;
            e_hi     = fin || (acc && id_md_op == 3'd5);
            e_lo     = fin || (acc && id_md_op == 3'd6);
            e_wsel   = acc && (id_md_op == 3'd5 || id_md_op == 3'd6);
            if (acc) begin
                if (was_busy && left == 1 && (id_wb_src == 3'd2 || id_wb_src == 3'd3) && !s
                    && !(id_md_op >= 3'd1 && id_md_op <= 3'd6))
                    e_wb = (id_wb_src == 3'd2) ? 3'd5 : 3'd6;
                else
                    e_wb = (id_wb_src > 3'd4) ? 3'd0 : id_wb_src;
            end
            if (e_start) begin
                e_op = 2'(id_md_op - 3'd1);
                left = (id_md_op >= 3'd3) ? DIV : MUL;
            end else if (was_busy) begin
                left = flush ? 0 : left - 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk) begin
            check("stall", stall, e_stall());
            check("busy", busy, left > 0);
            check("md_start", md_start, e_start);
            check("md_cancel", md_cancel, e_cancel);
            check("md_op", md_op, e_op);
            check("hi_we", hi_we, e_hi);
            check("lo_we", lo_we, e_lo);
            check("hilo_wsel", hilo_wsel, e_wsel);
            check("wb_sel", wb_sel, e_wb);
        end
    end

    task automatic step(input logic v, input logic [2:0] op, input logic [2:0] src, input logic fl);
        @(posedge clk);
        #1;
        id_valid = v; id_md_op = op; id_wb_src = src; flush = fl;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 3'd0, 3'd0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int ns, nw;
        bit got;
        idle(2);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_wb_sel", wb_sel, 0);
        check("rst_md_start", md_start, 0);
        check("rst_hi_we", hi_we, 0);
        rst = 1'b0;

        step(1, 3'd1, 3'd0, 0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 3'd0, 3'd0, 0);
            @(negedge clk);
            check("mult_busy_lit", busy, i <= 4);
            if (i == 1) begin
                check("mult_start_lit", md_start, 1);
                check("mult_op_lit", md_op, 0);
            end
            if (i == 5) begin
                check("mult_hi_lit", hi_we, 1);
                check("mult_lo_lit", lo_we, 1);
                check("mult_wsel_lit", hilo_wsel, 0);
            end
        end

        step(1, 3'd4, 3'd0, 0);
        ns = 0; got = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            step(1, 3'd0, 3'd3, 0);
            @(negedge clk);
            if (i == 1) check("divu_op_lit", md_op, 3);
            if (stall) ns++;
            else begin
                got = 1;
                check("mflo_accept_cycle", i, 34);
                check("mflo_hi_we_lit", hi_we, 1);
            end
        end
        check("divu_stall_cycles", ns, 33);
        idle(1);
        @(negedge clk);
        check("mflo_wb_sel_lit", wb_sel, 3);

        step(1, 3'd3, 3'd0, 0);
        idle(9);
        step(0, 3'd0, 3'd0, 1);
        idle(1);
        @(negedge clk);
        check("div_cancel_lit", md_cancel, 1);
        check("div_cancel_busy", busy, 0);
        nw = 0;
        for (int i = 12; i <= 40; i++) begin
            idle(1);
            @(negedge clk);
            nw += int'(hi_we | lo_we);
        end
        check("div_cancel_no_we", nw, 0);

        step(1, 3'd1, 3'd0, 0);
        idle(3);
        step(0, 3'd0, 3'd0, 1);
        idle(1);
        @(negedge clk);
        check("last_flush_cancel", md_cancel, 1);
        check("last_flush_no_we", hi_we, 0);

        step(1, 3'd5, 3'd0, 0);
        idle(1);
        @(negedge clk);
        check("mthi_hi", hi_we, 1);
        check("mthi_lo", lo_we, 0);
        check("mthi_wsel", hilo_wsel, 1);
        step(1, 3'd6, 3'd0, 0);
        idle(1);
        @(negedge clk);
        check("mtlo_lo", lo_we, 1);
        check("mtlo_hi", hi_we, 0);

        step(1, 3'd1, 3'd0, 0);
        step(1, 3'd0, 3'd4, 0);
        @(negedge clk);
        check("link_busy_stall", stall, 0);
        step(1, 3'd0, 3'd0, 0);
        @(negedge clk);
        check("add_busy_stall", stall, 0);
        check("link_wb_sel", wb_sel, 4);
        idle(1);
        @(negedge clk);
        check("add_wb_sel", wb_sel, 0);
        idle(3);

        step(1, 3'd0, 3'd4, 0);
        step(1, 3'd0, 3'd7, 0);
        @(negedge clk);
        check("pre_inv_wb_sel", wb_sel, 4);
        idle(1);
        @(negedge clk);
        check("inv_wb_sel", wb_sel, 0);

        step(1, 3'd0, 3'd4, 0);
        step(1, 3'd0, 3'd2, 1);
        idle(1);
        @(negedge clk);
        check("flush_idle_wb_sel", wb_sel, 4);

        step(1, 3'd1, 3'd0, 0);
        idle(3);
        step(1, 3'd0, 3'd2, 0);
        @(negedge clk);
`ifdef HILO_FWD_EN
        check("fwd_stall", stall, 0);
        idle(1);
        @(negedge clk);
        check("fwd_wb_sel", wb_sel, 5);
`else
        check("nofwd_stall", stall, 1);
        step(1, 3'd0, 3'd2, 0);
        @(negedge clk);
        check("nofwd_accept", stall, 0);
        idle(1);
        @(negedge clk);
        check("nofwd_wb_sel", wb_sel, 2);
`endif
        idle(3);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
